// File: rtl/pc_fetch_sequencer.sv
// Q1-Q4 phase generator, 13-bit PC, PCLATH and circular return stack; control inputs act only at the end-of-Q4 edge.
// Fetch address is registered (one slot of lookahead); no backpressure, the slot cadence is fixed at four clocks.
module pc_fetch_sequencer #(
  parameter int          STACK_DEPTH  = 8,
  parameter logic [12:0] RESET_VECTOR = 13'h0000,
  localparam int         SP_W         = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [1:0]      q_phase,
  output logic            instr_rd_en,
  output logic [12:0]     pc_out,
  output logic            flush,
  output logic [4:0]      pclath_out,
  input  logic            goto_en,
  input  logic            call_en,
  input  logic            ret_en,
  input  logic            skip_en,
  input  logic            pcl_wr_en,
  input  logic [7:0]      pcl_data_in,
  input  logic            pclath_wr_en,
  input  logic [4:0]      pclath_data_in,
  input  logic [10:0]     k,
  output logic [SP_W-1:0] stk_ptr
);

  logic [1:0]      phase_q, phase_d;
  logic [12:0]     pc_q, pc_d, pc_inc;
  logic [4:0]      pclath_q, pclath_d;
  logic [SP_W-1:0] sp_q, sp_d, sp_inc, sp_dec;
  logic            flush_q, flush_d;
  logic            push_en;
  logic [12:0]     stack_q [STACK_DEPTH];

  assign pc_inc = pc_q + 13'd1;
  assign sp_inc = sp_q + SP_W'(1);
  assign sp_dec = sp_q - SP_W'(1);

  always_comb begin
    phase_d  = phase_q + 2'd1;
    pc_d     = pc_q;
    pclath_d = pclath_q;
    sp_d     = sp_q;
    flush_d  = flush_q;
    push_en  = 1'b0;
    if (phase_q == 2'd3) begin
      if (flush_q) begin
        // Discarded slot: controls are meaningless, just keep fetching sequentially.
        pc_d    = pc_inc;
        flush_d = 1'b0;
      end else begin
        flush_d = 1'b1;
        if (pclath_wr_en)
          pclath_d = pclath_data_in;
        // Branch targets below use pclath_q so a same-slot PCLATH write takes effect next slot.
        if (ret_en) begin
          pc_d = stack_q[sp_dec];
          sp_d = sp_dec;
        end else if (call_en) begin
          push_en = 1'b1;
          sp_d    = sp_inc;
          pc_d    = {pclath_q[4:3], k};
        end else if (goto_en) begin
          pc_d = {pclath_q[4:3], k};
        end else if (pcl_wr_en) begin
          pc_d = {pclath_q, pcl_data_in};
        end else begin
          pc_d    = pc_inc;
          flush_d = skip_en;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= 2'd0;
      pc_q     <= RESET_VECTOR;
      pclath_q <= 5'd0;
      sp_q     <= '0;
      flush_q  <= 1'b1;
      for (int i = 0; i < STACK_DEPTH; i++)
        stack_q[i] <= 13'd0;
    end else begin
      phase_q  <= phase_d;
      pc_q     <= pc_d;
      pclath_q <= pclath_d;
      sp_q     <= sp_d;
      flush_q  <= flush_d;
      if (push_en)
        stack_q[sp_q] <= pc_q;
    end
  end

  assign q_phase     = phase_q;
  assign instr_rd_en = (phase_q == 2'd3);
  assign pc_out      = pc_q;
  assign flush       = flush_q;
  assign pclath_out  = pclath_q;
  assign stk_ptr     = sp_q;

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Upstream stage of the midrange core. Generates the Q1-Q4 instruction-cycle phase and owns the 13-bit program counter, the PCLATH register and the hardware return stack.
- Drives the program_memory address and read enable.
- Flags flushed instruction slots; the decoder executes those as forced NOPs after any PC discontinuity.

Parameters:
- STACK_DEPTH, 8, number of return-stack entries (power of 2; pointer width = log2).
- RESET_VECTOR, 13'h0000, PC value loaded on reset.

Ports:
- clk  input  1  core clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- q_phase  output  2  current phase: 0=Q1, 1=Q2, 2=Q3, 3=Q4.
- instr_rd_en  output  1  program_memory read enable; high only in Q4.
- pc_out  output  13  program_memory address.
- flush  output  1  high for the whole 4-clock slot whose instruction must be treated as NOP.
- pclath_out  output  5  current PCLATH.
- goto_en  input  1  execute GOTO this slot.
- call_en  input  1  execute CALL this slot.
- ret_en  input  1  RETURN / RETLW / RETFIE this slot.
- skip_en  input  1  conditional skip taken this slot.
- pcl_wr_en  input  1  instruction writes PCL.
- pcl_data_in  input  8  new PCL value.
- pclath_wr_en  input  1  instruction writes PCLATH.
- pclath_data_in  input  5  new PCLATH value.
- k  input  11  GOTO/CALL literal.
- stk_ptr  output  log2(STACK_DEPTH)  stack pointer, for debug and verification.

Behaviour:
- Reset (async, rst_n=0): q_phase=0, pc_out=RESET_VECTOR, pclath_out=0, stk_ptr=0, stack entries=0, flush=1. The first slot after reset is a forced NOP because the instruction register holds no valid instruction.
- Phase counter: advances every clock 0→1→2→3→0. instr_rd_en = (q_phase==3), combinational.
- Control inputs are sampled only on the clock edge that ends Q4 (q_phase==3). They are ignored in Q1-Q3 and throughout any slot with flush=1.
- Pipeline: while the instruction at A executes, pc_out=A+1. At the end-of-Q4 edge, program_memory latches instr[pc_out], then the PC update below applies.
- PC update priority at the end-of-Q4 edge (highest first):
  - ret_en: pc ← stack[stk_ptr-1]; stk_ptr decrements; next flush=1.
  - call_en: stack[stk_ptr] ← pc_out; stk_ptr increments; pc ← {pclath[4:3], k}; next flush=1.
  - goto_en: pc ← {pclath[4:3], k}; next flush=1.
  - pcl_wr_en: pc ← {pclath[4:0], pcl_data_in}; next flush=1.
  - skip_en: pc ← pc+1; next flush=1.
  - default: pc ← pc+1; next flush=0.
- Flushed slot: pc ← pc+1 at its Q4 edge; next flush=0 unconditionally.
- PC arithmetic is 13-bit and wraps: 13'h1FFF+1 = 0.
- PCLATH: written at the end-of-Q4 edge when pclath_wr_en=1 (non-flushed slot). Any goto/call/pcl write in the same slot uses the OLD pclath value.
- Stack is circular, with no overflow or underflow flags:
  - Push at stk_ptr = STACK_DEPTH-1 wraps the pointer to 0 and overwrites the oldest entry (the 9th CALL overwrites entry 0).
  - Pop at stk_ptr = 0 wraps to STACK_DEPTH-1 and returns that entry.
- Simultaneous ret_en+call_en: return wins and no push occurs. Any other multi-assertion resolves by the priority list above.
- Reset asserted mid-slot: immediate return to the reset state. The slot after release is flushed.

Test Plan:
- Reset, then run with all controls 0 → flush=1 for the first slot. Fetches occur at pc 0,1,2,… on each Q4. instr_rd_en is high only when q_phase==3. pc_out=3 after 3 slots.
- pclath=5'h18, goto_en with k=11'h123 → pc_out=13'h1923. The following slot has flush=1. The next fetch is at 13'h1923, then pc=13'h1924.
- CALL from executing address 13'h0010 (pc_out=13'h0011), k=11'h200, pclath=0 → stack[0]=13'h0011, stk_ptr=1, pc=13'h0200. A later ret_en → pc=13'h0011, stk_ptr=0, flush=1 on both discontinuities.
- Nine nested CALLs, then nine RETURNs → the 9th return address overwrites entry 0 and stk_ptr wraps 7→0. Returns yield addresses 9,8,…,2, then 9 again (the overwritten entry).
- pcl_wr_en with data 8'hA5 and pclath_wr_en with data 5'h03 in the same slot, old pclath=5'h01 → pc=13'h01A5 and pclath_out=5'h03. skip_en → pc+1 with flush=1.
- rst_n pulsed low during Q3 of a CALL slot → outputs go to reset values immediately, the stack is not pushed, and the first slot after release is flushed.
